// File: rtl/ring_osc_gen.sv
// ring_osc_gen -- clocked model of a tunable N-stage inverter ring oscillator.
//
// The ring is a vector of STAGES stage bits. A pointer walks round the ring and
// toggles one stage per step: the stage under the pointer takes the inverse of
// its upstream neighbour (stage 0 is fed from stage STAGES-1). Steps occur every
// dly+1 enabled clock cycles, so osc_out has a period of 2*STAGES*(dly+1) cycles.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   en         in   run enable; low freezes all state
//   clr        in   synchronous clear back to the reset pattern
//   dly        in   per-stage delay (DLY_W bits), sampled only at a step
//   taps       out  stage vector, bit i = stage i
//   osc_out    out  oscillator output, equal to taps[STAGES-1]
//   edge_cnt   out  saturating count of osc_out rising edges (CNT_W bits)
//   running    out  registered copy of (en & ~clr)
//   period     out  last measured osc_out period in clk cycles (CNT_W bits)
//   period_vld out  one-cycle pulse when period updates
//
// Optional feature macro: RING_OSC_PERIOD_MEAS_EN
//   Defined   -> period measurement logic is built.
//   Undefined -> period and period_vld are tied to zero (ports remain).

module ring_osc_gen #(
  parameter int STAGES = 5,
  parameter int DLY_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic [DLY_W-1:0]  dly,
  output logic [STAGES-1:0] taps,
  output logic              osc_out,
  output logic [CNT_W-1:0]  edge_cnt,
  output logic              running,
  output logic [CNT_W-1:0]  period,
  output logic              period_vld
);

  generate
    if (((STAGES % 2) == 0) || (STAGES < 3)) begin : g_bad_stages
      $error("ring_osc_gen: STAGES must be odd and >= 3");
    end
  endgenerate

  localparam int PW = $clog2(STAGES);
  localparam logic [PW-1:0] LAST = PW'(STAGES - 1);

  // Alternating 0/1 pattern, stage i = i mod 2.
  function automatic logic [STAGES-1:0] init_pattern();
    logic [STAGES-1:0] v;
    for (int i = 0; i < STAGES; i++) begin
      v[i] = 1'((i % 2));
    end
    return v;
  endfunction

  localparam logic [STAGES-1:0] INIT = init_pattern();

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [STAGES-1:0] s;
  logic [PW-1:0]     p;
  logic [DLY_W-1:0]  dcnt;
  logic [PW-1:0]     prev_idx;
  logic              fb;
  logic              step;
  logic              rise;

  assign step     = en && (dcnt == '0);
  assign prev_idx = (p == '0) ? LAST : p - 1'b1;
  assign fb       = s[prev_idx];
  // The last stage rises when it is the one being stepped, is currently 0,
  // and its upstream neighbour is 0 (so the new value ~fb is 1).
  assign rise     = step && (p == LAST) && !s[STAGES-1] && !fb;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s        <= INIT;
      p        <= '0;
      dcnt     <= '0;
      edge_cnt <= '0;
      running  <= 1'b0;
    end else begin
      running <= en & ~clr;
      if (clr) begin
        s        <= INIT;
        p        <= '0;
        dcnt     <= '0;
        edge_cnt <= '0;
      end else if (en) begin
        if (step) begin
          s[p] <= ~fb;
          p    <= (p == LAST) ? '0 : p + 1'b1;
          dcnt <= dly;
          if (rise) begin
            edge_cnt <= sat_inc(edge_cnt);
          end
        end else begin
          dcnt <= dcnt - 1'b1;
        end
      end
    end
  end

  assign taps    = s;
  assign osc_out = s[STAGES-1];

`ifdef RING_OSC_PERIOD_MEAS_EN
  logic [CNT_W-1:0] pcnt;
  logic             seen;

  // pcnt restarts at 1 on each rising edge, so the value it holds when the
  // next rising edge arrives is the number of enabled cycles in between.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt       <= '0;
      seen       <= 1'b0;
      period     <= '0;
      period_vld <= 1'b0;
    end else if (clr) begin
      pcnt       <= '0;
      seen       <= 1'b0;
      period     <= '0;
      period_vld <= 1'b0;
    end else if (en) begin
      period_vld <= 1'b0;
      if (rise) begin
        pcnt <= CNT_W'(1);
        seen <= 1'b1;
        if (seen) begin
          period     <= pcnt;
          period_vld <= 1'b1;
        end
      end else begin
        pcnt <= sat_inc(pcnt);
      end
    end else begin
      period_vld <= 1'b0;
    end
  end
`else
  assign period     = '0;
  assign period_vld = 1'b0;
`endif

endmodule

// File: tb/tb_ring_osc_gen.sv
// Directed testbench for ring_osc_gen (STAGES=5) plus a CNT_W=4 instance
// used to exercise edge counter saturation.

module tb_ring_osc_gen;

`ifdef RING_OSC_PERIOD_MEAS_EN
  localparam bit PM_EN = 1'b1;
`else
  localparam bit PM_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        clr;
  logic [7:0]  dly;
  logic [4:0]  taps;
  logic        osc_out;
  logic [15:0] edge_cnt;
  logic        running;
  logic [15:0] period;
  logic        period_vld;

  logic        en_s;
  logic        clr_s;
  logic [7:0]  dly_s;
  logic [4:0]  taps_s;
  logic        osc_s;
  logic [3:0]  edge_s;
  logic        running_s;
  logic [3:0]  period_s;
  logic        pvld_s;

  int n_cmp = 0;
  int n_err = 0;

  ring_osc_gen #(.STAGES(5), .DLY_W(8), .CNT_W(16)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .clr        (clr),
    .dly        (dly),
    .taps       (taps),
    .osc_out    (osc_out),
    .edge_cnt   (edge_cnt),
    .running    (running),
    .period     (period),
    .period_vld (period_vld)
  );

  ring_osc_gen #(.STAGES(5), .DLY_W(8), .CNT_W(4)) u_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en_s),
    .clr        (clr_s),
    .dly        (dly_s),
    .taps       (taps_s),
    .osc_out    (osc_s),
    .edge_cnt   (edge_s),
    .running    (running_s),
    .period     (period_s),
    .period_vld (pvld_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until osc_out is seen going 0->1; cyc = edges taken.
  task automatic wait_rise(output int cyc);
    logic prev;
    cyc  = 0;
    prev = osc_out;
    while (cyc < 1000) begin
      tick();
      cyc++;
      if (!prev && osc_out) return;
      prev = osc_out;
    end
    check("rise_timeout", 32'd0, 32'd1);
  endtask

  // Advance until osc_out changes level; cyc = edges spent at the old level.
  task automatic measure_level(output int cyc);
    logic lvl;
    cyc = 0;
    lvl = osc_out;
    while (cyc < 1000) begin
      tick();
      cyc++;
      if (osc_out != lvl) return;
    end
    check("level_timeout", 32'd0, 32'd1);
  endtask

  logic [4:0] step_tbl [5];
  int cyc;

  initial begin
    step_tbl[0] = 5'b01011;
    step_tbl[1] = 5'b01001;
    step_tbl[2] = 5'b01101;
    step_tbl[3] = 5'b00101;
    step_tbl[4] = 5'b10101;

    rst_n = 1'b0; en = 1'b0; clr = 1'b0; dly = 8'd0;
    en_s  = 1'b0; clr_s = 1'b0; dly_s = 8'd0;
    repeat (3) tick();
    rst_n = 1'b1;

    // Reset state, held with en=0
    check("rst_osc", osc_out, 1'b0);
    check("rst_edge", edge_cnt, 16'd0);
    check("rst_running", running, 1'b0);
    check("rst_period", period, 16'd0);
    check("rst_pvld", period_vld, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rst_hold_taps", taps, 5'b01010);
    end
    check("rst_hold_edge", edge_cnt, 16'd0);

    // Step sequence, dly=0
    en = 1'b1; dly = 8'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("step_taps", taps, step_tbl[i]);
    end
    check("step_edge1", edge_cnt, 16'd1);
    check("step_running", running, 1'b1);
    wait_rise(cyc);
    check("period_dly0", cyc, 10);
    check("step_edge2", edge_cnt, 16'd2);

    // Clear pulse
    clr = 1'b1;
    tick();
    check("clr_taps", taps, 5'b01010);
    check("clr_edge", edge_cnt, 16'd0);
    check("clr_running", running, 1'b0);
    clr = 1'b0;

    // Programmable delay dly=3
    dly = 8'd3;
    wait_rise(cyc);
    check("dly3_first_rise", cyc, 17);
    measure_level(cyc);
    check("dly3_high", cyc, 20);
    measure_level(cyc);
    check("dly3_low", cyc, 20);
    check("dly3_edge", edge_cnt, 16'd2);

    // dly change mid-delay: current 4-cycle step finishes first
    dly = 8'd0;
    measure_level(cyc);
    check("dly_change_high", cyc, 8);
    check("dly_change_taps", taps, 5'b01010);

    // Freeze for 7 cycles, then resume without skipping a step
    en = 1'b0;
    repeat (7) tick();
    check("freeze_taps", taps, 5'b01010);
    check("freeze_edge", edge_cnt, 16'd2);
    check("freeze_running", running, 1'b0);
    en = 1'b1;
    tick();
    check("resume_taps0", taps, 5'b01011);
    tick();
    check("resume_taps1", taps, 5'b01001);
    repeat (3) tick();
    check("resume_taps4", taps, 5'b10101);
    check("resume_edge", edge_cnt, 16'd3);

    // Period measurement, dly=1
    clr = 1'b1;
    tick();
    clr = 1'b0;
    dly = 8'd1;
    check("pm_clr_period", period, 16'd0);
    check("pm_clr_pvld", period_vld, 1'b0);
    wait_rise(cyc);
    check("pm_first_rise", cyc, 9);
    check("pm_first_pvld", period_vld, 1'b0);
    wait_rise(cyc);
    check("pm_second_rise", cyc, 20);
    check("pm_second_pvld", period_vld, PM_EN ? 1'b1 : 1'b0);
    check("pm_period", period, PM_EN ? 16'd20 : 16'd0);
    tick();
    check("pm_pvld_drop", period_vld, 1'b0);
    check("pm_period_hold", period, PM_EN ? 16'd20 : 16'd0);

    // Edge counter saturation on the CNT_W=4 instance
    en_s = 1'b1;
    repeat (140) tick();
    check("sat_edge_140", edge_s, 4'd14);
    repeat (5) tick();
    check("sat_edge_145", edge_s, 4'd15);
    repeat (55) tick();
    check("sat_edge_200", edge_s, 4'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ring_osc_gen.md
Name: ring_osc_gen

Overview:
- Synthesizable, clocked model of a tunable N-stage inverter ring oscillator.
- Successor to the fixed 5-inverter transistor ring: stage count and per-stage delay are now parametrised/programmable, with enable, clear and edge counting added.
- Produces the ring's stage taps and an oscillator output for test-clock generation and for ring-oscillator characterisation in the logic-converter flow.

Parameters:
- STAGES, 5, number of inverter stages; must be odd and >= 3.
- DLY_W, 8, width of the per-stage delay input.
- CNT_W, 16, width of the edge counter and period counter.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- en  input  1  run enable; low freezes all state.
- clr  input  1  synchronous clear to the reset pattern.
- dly  input  DLY_W  per-stage delay; one stage step every dly+1 enabled cycles.
- taps  output  STAGES  ring stage values; bit i = stage i.
- osc_out  output  1  oscillator output, equal to taps[STAGES-1].
- edge_cnt  output  CNT_W  count of osc_out rising edges, saturating.
- running  output  1  registered copy of (en & ~clr).
- period  output  CNT_W  last measured osc_out period in clk cycles (optional feature).
- period_vld  output  1  one-cycle pulse when period updates (optional feature).

Behaviour:
- Internal state:
  - s[STAGES-1:0] is the stage vector.
  - p is the stage pointer, 0..STAGES-1.
  - dcnt is the delay counter, DLY_W bits.
- Reset (rst_n=0 at clk edge):
  - s[i] = i mod 2, so taps = ...01010 and osc_out = 0.
  - p = 0, dcnt = 0, edge_cnt = 0, running = 0, period = 0, period_vld = 0.
- Priority: rst_n > clr > en.
- clr=1 (with rst_n=1): same values as reset, except running = 0 as well.
- en=0: s, p, dcnt and edge_cnt all hold; period_vld = 0. A later en=1 resumes exactly where the block stopped.
- en=1 and dcnt==0 is a step:
  - s[p] <= ~s[(p-1) mod STAGES], with stage 0 fed from stage STAGES-1.
  - p <= (p==STAGES-1) ? 0 : p+1.
  - dcnt <= dly. dly is sampled only at a step; a change mid-delay takes effect at the next step.
- en=1 and dcnt!=0: dcnt <= dcnt-1.
- Timing:
  - The first step occurs on the first enabled edge after reset or clr.
  - Exactly one stage toggles per step.
  - osc_out period = 2*STAGES*(dly+1) clk cycles, for constant dly.
- Edge counter:
  - edge_cnt increments on the step where stage STAGES-1 goes 0->1.
  - It is visible in the same cycle as the taps update.
  - It saturates at 2^CNT_W-1 and never wraps.
- taps/osc_out are registered directly from s, with no combinational path from the inputs.
- Elaboration: a non-odd STAGES or STAGES < 3 is an error.

Optional Feature:
- Macro: RING_OSC_PERIOD_MEAS_EN.
- Defined:
  - A CNT_W cycle counter runs on enabled cycles. It resets to 1 at each osc_out rising edge.
  - At each rising edge after the first one since reset/clr: period <= counter value before reset, and period_vld pulses for 1 cycle.
  - The counter saturates at all-ones.
  - en=0 cycles are not counted.
- Undefined: period is tied to 0 and period_vld to 0. The ports remain present.

Test Plan:
- Reset pattern: STAGES=5, hold rst_n=0 then release with en=0 -> taps=5'b01010, osc_out=0, edge_cnt=0, running=0, unchanged for 10 cycles.
- Step sequence: dly=0, en=1 -> taps on successive edges = 01011, 01001, 01101, 00101, 10101; edge_cnt=1 on 5th edge; osc_out period=10 cycles thereafter.
- Programmable delay: dly=3 -> osc_out high 20 / low 20 cycles; change dly to 0 mid-delay -> new rate starts only after the current 4-cycle step completes.
- Enable/clear: deassert en for 7 cycles mid-run -> taps, edge_cnt frozen, resume without a skipped step; pulse clr -> next cycle taps=01010, edge_cnt=0, running=0.
- Saturation: CNT_W=4, dly=0, run 200 cycles -> edge_cnt reaches 15 and stays 15.
- Period measurement (RING_OSC_PERIOD_MEAS_EN, dly=1): no period_vld on the first rising edge; on the second, period=20 with a 1-cycle period_vld; without the macro, period=0 and period_vld=0 throughout.
